// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the non-pipelined MIPS core: one-hot phase bus,
// per-phase control strobes decoded from (state, latched op), retire counter.
module multicycle_control_fsm #(
  parameter int unsigned ImemDepth = 135,
  parameter logic [5:0]  HaltOp    = 6'b111111
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] pc_addr_i,
  output logic [5:0]  state_o,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] instr_count_o
);

  localparam logic [5:0] StIdle   = 6'b000001;
  localparam logic [5:0] StFetch  = 6'b000010;
  localparam logic [5:0] StDecode = 6'b000100;
  localparam logic [5:0] StExec   = 6'b001000;
  localparam logic [5:0] StMem    = 6'b010000;
  localparam logic [5:0] StWb     = 6'b100000;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  logic [5:0]  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic        retire;

  always_comb begin
    state_d  = StIdle;
    op_d     = op_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    case (state_q)
      StIdle: begin
        state_d = (start_i && !halted_q) ? StFetch : StIdle;
      end
      StFetch: begin
        if (pc_addr_i >= 32'(ImemDepth)) begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = StIdle;
        end else begin
          op_d    = opcode_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_q == OpJ) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (op_q == HaltOp) begin
          halted_d = 1'b1;
          retire   = 1'b1;
          state_d  = StIdle;
        end else if (op_q == OpR || op_q == OpLw || op_q == OpSw ||
                     op_q == OpBeq || op_q == OpAddi) begin
          state_d = StExec;
        end else begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StExec: begin
        if (op_q == OpBeq) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (op_q == OpLw || op_q == OpSw) begin
          state_d = StMem;
        end else if (op_q == OpR || op_q == OpAddi) begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (op_q == OpLw) begin
          state_d = StWb;
        end else if (op_q == OpSw) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      // Illegal one-hot encodings fall back to IDLE.
      default: state_d = StIdle;
    endcase
    count_d = count_q + {31'd0, retire};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      op_q     <= 6'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  // Strobes depend only on registered state and op, never on opcode_i.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_o       = 1'b0;
    alu_op_o        = 2'b00;
    case (state_q)
      StDecode: begin
        pc_write_o = (op_q == OpJ);
      end
      StExec: begin
        if (op_q == OpR) begin
          alu_op_o = 2'b10;
        end else if (op_q == OpLw || op_q == OpSw || op_q == OpAddi) begin
          alu_src_o = 1'b1;
        end else if (op_q == OpBeq) begin
          alu_op_o        = 2'b01;
          pc_write_cond_o = 1'b1;
        end
      end
      StMem: begin
        if (op_q == OpLw) begin
          mem_read_o = 1'b1;
        end else if (op_q == OpSw) begin
          mem_write_o = 1'b1;
          pc_write_o  = 1'b1;
        end
      end
      StWb: begin
        reg_write_o  = 1'b1;
        pc_write_o   = 1'b1;
        reg_dst_o    = (op_q == OpR);
        mem_to_reg_o = (op_q == OpLw);
      end
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  opcode;
  logic [31:0] pc_addr;
  logic [5:0]  state;
  logic        pc_write, pc_write_cond, mem_read, mem_write, reg_write;
  logic        mem_to_reg, reg_dst, alu_src, halted, fault;
  logic [1:0]  alu_op;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .opcode_i       (opcode),
    .pc_addr_i      (pc_addr),
    .state_o        (state),
    .pc_write_o     (pc_write),
    .pc_write_cond_o(pc_write_cond),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .reg_write_o    (reg_write),
    .mem_to_reg_o   (mem_to_reg),
    .reg_dst_o      (reg_dst),
    .alu_src_o      (alu_src),
    .alu_op_o       (alu_op),
    .halted_o       (halted),
    .fault_o        (fault),
    .instr_count_o  (instr_count)
  );

  // Strobe bundle order: pc_write, pc_write_cond, mem_read, mem_write,
  // reg_write, mem_to_reg, reg_dst, alu_src.
  typedef struct {
    string       name;
    logic [5:0]  st;
    logic [7:0]  sb;
    logic [1:0]  aop;
    logic        h;
    logic        f;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [5:0] I = 6'b000001, F = 6'b000010, D = 6'b000100;
  localparam logic [5:0] E = 6'b001000, M = 6'b010000, W = 6'b100000;

  task automatic tick(input string name, input logic [5:0] st, input logic [7:0] sb,
                      input logic [1:0] aop, input logic h, input logic f,
                      input logic [31:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name; e.st = st; e.sb = sb; e.aop = aop; e.h = h; e.f = f; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] sb;
      e  = exp_q.pop_front();
      sb = {pc_write, pc_write_cond, mem_read, mem_write, reg_write, mem_to_reg,
            reg_dst, alu_src};
      total++;
      if (state !== e.st || sb !== e.sb || alu_op !== e.aop || halted !== e.h ||
          fault !== e.f || instr_count !== e.cnt) begin
        bad++;
        $display("FAIL %s: got st=%b sb=%b aop=%b h=%b f=%b cnt=%0d want st=%b sb=%b aop=%b h=%b f=%b cnt=%0d",
                 e.name, state, sb, alu_op, halted, fault, instr_count,
                 e.st, e.sb, e.aop, e.h, e.f, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'd0; pc_addr = 32'd0;
    tick("reset0", I, 8'h00, 2'b00, 0, 0, 0);
    tick("reset1", I, 8'h00, 2'b00, 0, 0, 0);
    reset = 1'b0;
    tick("idle_nostart", I, 8'h00, 2'b00, 0, 0, 0);

    // R-type at pc 0
    start = 1'b1; opcode = 6'b000000; pc_addr = 32'd0;
    tick("r_fetch", F, 8'h00, 2'b00, 0, 0, 0);
    tick("r_decode", D, 8'h00, 2'b00, 0, 0, 0);
    opcode = 6'b111111;  // garbage outside FETCH must not matter
    tick("r_exec", E, 8'b00000000, 2'b10, 0, 0, 0);
    tick("r_wb", W, 8'b10001010, 2'b00, 0, 0, 0);
    // lw, start dropped: sequencer keeps running
    start = 1'b0; opcode = 6'b100011; pc_addr = 32'd1;
    tick("r_to_fetch", F, 8'h00, 2'b00, 0, 0, 1);
    tick("lw_decode", D, 8'h00, 2'b00, 0, 0, 1);
    tick("lw_exec", E, 8'b00000001, 2'b00, 0, 0, 1);
    tick("lw_mem", M, 8'b00100000, 2'b00, 0, 0, 1);
    tick("lw_wb", W, 8'b10001100, 2'b00, 0, 0, 1);
    opcode = 6'b101011; pc_addr = 32'd2;
    tick("lw_to_fetch", F, 8'h00, 2'b00, 0, 0, 2);
    tick("sw_decode", D, 8'h00, 2'b00, 0, 0, 2);
    tick("sw_exec", E, 8'b00000001, 2'b00, 0, 0, 2);
    tick("sw_mem", M, 8'b10010000, 2'b00, 0, 0, 2);
    opcode = 6'b000100; pc_addr = 32'd3;
    tick("sw_to_fetch", F, 8'h00, 2'b00, 0, 0, 3);
    tick("beq_decode", D, 8'h00, 2'b00, 0, 0, 3);
    tick("beq_exec", E, 8'b01000000, 2'b01, 0, 0, 3);
    opcode = 6'b000010; pc_addr = 32'd4;
    tick("beq_to_fetch", F, 8'h00, 2'b00, 0, 0, 4);
    tick("j_decode", D, 8'b10000000, 2'b00, 0, 0, 4);
    opcode = 6'b001000; pc_addr = 32'd5;
    tick("j_to_fetch", F, 8'h00, 2'b00, 0, 0, 5);
    tick("addi_decode", D, 8'h00, 2'b00, 0, 0, 5);
    tick("addi_exec", E, 8'b00000001, 2'b00, 0, 0, 5);
    tick("addi_wb", W, 8'b10001000, 2'b00, 0, 0, 5);
    opcode = 6'b111111; pc_addr = 32'd6;
    tick("addi_to_fetch", F, 8'h00, 2'b00, 0, 0, 6);
    tick("halt_decode", D, 8'h00, 2'b00, 0, 0, 6);
    start = 1'b1;
    tick("halt_idle", I, 8'h00, 2'b00, 1, 0, 7);
    tick("halt_sticky", I, 8'h00, 2'b00, 1, 0, 7);

    // PC boundary: 134 legal, 135 faults without counting
    reset = 1'b1;
    tick("reset_after_halt", I, 8'h00, 2'b00, 0, 0, 0);
    reset = 1'b0; opcode = 6'b000010; pc_addr = 32'd134;
    tick("pc134_fetch", F, 8'h00, 2'b00, 0, 0, 0);
    tick("pc134_j_decode", D, 8'b10000000, 2'b00, 0, 0, 0);
    pc_addr = 32'd135;
    tick("pc135_fetch", F, 8'h00, 2'b00, 0, 0, 1);
    tick("pc135_fault", I, 8'h00, 2'b00, 1, 1, 1);
    tick("pc135_stays_idle", I, 8'h00, 2'b00, 1, 1, 1);

    // Illegal opcode
    reset = 1'b1;
    tick("reset_after_fault", I, 8'h00, 2'b00, 0, 0, 0);
    reset = 1'b0; opcode = 6'b010101; pc_addr = 32'd0;
    tick("ill_fetch", F, 8'h00, 2'b00, 0, 0, 0);
    tick("ill_decode", D, 8'h00, 2'b00, 0, 0, 0);
    tick("ill_fault", I, 8'h00, 2'b00, 1, 1, 0);

    // Reset mid-lw abandons it
    reset = 1'b1;
    tick("reset_again", I, 8'h00, 2'b00, 0, 0, 0);
    reset = 1'b0; opcode = 6'b000010;
    tick("pre_j_fetch", F, 8'h00, 2'b00, 0, 0, 0);
    tick("pre_j_decode", D, 8'b10000000, 2'b00, 0, 0, 0);
    opcode = 6'b100011;
    tick("mid_fetch", F, 8'h00, 2'b00, 0, 0, 1);
    tick("mid_decode", D, 8'h00, 2'b00, 0, 0, 1);
    tick("mid_exec", E, 8'b00000001, 2'b00, 0, 0, 1);
    tick("mid_mem", M, 8'b00100000, 2'b00, 0, 0, 1);
    reset = 1'b1;
    tick("reset_in_mem", I, 8'h00, 2'b00, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
